// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-to-RAM subsystem: state encodings and word widths.
// Used by the SPI slave front end, the RAM and the top wrapper.
package spi_pkg;

    localparam int WORD_W = 10;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_t;

    // Progress of the MISO read-back inside a READ_DATA frame
    typedef enum logic [1:0] {
        TX_OFF,
        TX_WAIT,
        TX_SHIFT,
        TX_DONE
    } tx_phase_t;

endpackage

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises MOSI into command words for the RAM and
// serialises the RAM read byte back out on MISO. SCK is used directly as clk.
module spi_slave_if #(
    parameter int WORD_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);
    import spi_pkg::*;

    spi_state_t        state, state_next;
    tx_phase_t         tx_phase;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  tx_left;
    logic [WORD_W-2:0] rx_shift;
    logic [DATA_W-1:0] tx_shift;
    logic              word_done;
    logic              rd_addr_seen;
    logic              shift_bit;
    logic              last_bit;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        shift_bit  = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE: begin
                if (!ss_n) state_next = CHK_CMD;
            end
            CHK_CMD: begin
                if (ss_n)              state_next = IDLE;
                else if (!mosi)        state_next = WRITE;
                else if (rd_addr_seen) state_next = READ_DATA;
                else                   state_next = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                // An abort on the last-bit edge must win, so shifting is gated by ss_n
                if (ss_n) begin
                    state_next = IDLE;
                end else if (!word_done) begin
                    shift_bit = 1'b1;
                    last_bit  = (bit_cnt == CNT_W'(WORD_W - 1));
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: reset here is synchronous; rst_n is only looked at on a rising clk edge.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            miso         <= 1'b0;
            rd_addr_seen <= 1'b0;
            bit_cnt      <= '0;
            tx_left      <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            word_done    <= 1'b0;
            tx_phase     <= TX_OFF;
        end else begin
            rx_valid <= 1'b0;
            if (state_next == IDLE) begin
                // Idle or aborted frame: drop any partial word and read-back
                bit_cnt   <= '0;
                tx_left   <= '0;
                rx_shift  <= '0;
                tx_shift  <= '0;
                word_done <= 1'b0;
                tx_phase  <= TX_OFF;
                miso      <= 1'b0;
            end else begin
                if (shift_bit) begin
                    rx_shift <= {rx_shift[WORD_W-3:0], mosi};
                    bit_cnt  <= bit_cnt + CNT_W'(1);
                    if (last_bit) begin
                        rx_data   <= {rx_shift, mosi};
                        rx_valid  <= 1'b1;
                        word_done <= 1'b1;
                        bit_cnt   <= '0;
                        if (state == READ_ADD) rd_addr_seen <= 1'b1;
                        if (state == READ_DATA) begin
                            rd_addr_seen <= 1'b0;
                            tx_phase     <= TX_WAIT;
                        end
                    end
                end

                case (tx_phase)
                    TX_WAIT: begin
                        if (tx_valid) begin
                            miso     <= tx_data[DATA_W-1];
                            tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
                            tx_left  <= CNT_W'(DATA_W - 1);
                            tx_phase <= TX_SHIFT;
                        end
                    end
                    TX_SHIFT: begin
                        if (tx_left != '0) begin
                            miso     <= tx_shift[DATA_W-1];
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                            tx_left  <= tx_left - CNT_W'(1);
                        end else begin
                            miso     <= 1'b0;
                            tx_phase <= TX_DONE;
                        end
                    end
                    default: miso <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: a frame-level model schedules the expected
// rx_valid/rx_data/miso per clock edge and one process compares them every cycle.
module tb_spi_slave_if;
    import spi_pkg::*;

    localparam int WW   = 10;
    localparam int DW   = 8;
    localparam int NCYC = 4096;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          ss_n     = 1'b1;
    logic          mosi     = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data  = '0;
    logic          miso;
    logic          rx_valid;
    logic [WW-1:0] rx_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected outputs indexed by the clock edge after which they must appear
    bit            exp_rv   [NCYC];
    logic [WW-1:0] exp_rd   [NCYC];
    bit            exp_miso [NCYC];

    bit model_seen = 1'b0;
    bit tx_armed   = 1'b0;
    int path       = 0;   // 0 write, 1 read address, 2 read data

    spi_slave_if #(.WORD_W(WW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("rx_valid", rx_valid, exp_rv[cyc-1]);
            check("miso", miso, exp_miso[cyc-1]);
            if (exp_rv[cyc-1]) check("rx_data", rx_data, exp_rd[cyc-1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic edge_drive(input logic s, input logic m, input logic tv, input logic [DW-1:0] td);
        ss_n     = s;
        mosi     = m;
        tx_valid = tv;
        tx_data  = td;
        tick();
    endtask

    task automatic clear_miso_exp(input int from);
        for (int k = from; k < from + 16 && k < NCYC; k++) exp_miso[k] = 1'b0;
    endtask

    task automatic send_header(input bit sel);
        edge_drive(1'b0, 1'b0, 1'b0, '0);
        edge_drive(1'b0, sel, 1'b0, '0);
        path = !sel ? 0 : (model_seen ? 2 : 1);
    endtask

    // Sends the first n bits of w; the word completes only when n == WW
    task automatic send_word(input logic [WW-1:0] w, input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            if (i == WW - 1) begin
                exp_rv[cyc] = 1'b1;
                exp_rd[cyc] = w;
            end
            edge_drive(1'b0, w[WW-1-i], noise, 8'hFF);
        end
        if (n == WW) begin
            if (path == 1) model_seen = 1'b1;
            else if (path == 2) begin
                model_seen = 1'b0;
                tx_armed   = 1'b1;
            end
            check("rd_addr_seen_word", dut.rd_addr_seen, model_seen);
        end
    endtask

    task automatic send_tx(input logic [DW-1:0] b, input int delay);
        for (int d = 0; d < delay; d++) edge_drive(1'b0, 1'b1, 1'b0, 8'h81);
        if (tx_armed)
            for (int j = 0; j < DW; j++) exp_miso[cyc+j] = b[DW-1-j];
        tx_armed = 1'b0;
        edge_drive(1'b0, 1'b0, 1'b1, b);
    endtask

    task automatic hold(input int n, input bit tv);
        for (int i = 0; i < n; i++) edge_drive(1'b0, i[0], tv, 8'hC3);
    endtask

    task automatic end_frame();
        clear_miso_exp(cyc);
        tx_armed = 1'b0;
        edge_drive(1'b1, 1'b0, 1'b0, '0);
        check("state_after_ss", dut.state, IDLE);
        check("rd_addr_seen_frame", dut.rd_addr_seen, model_seen);
        edge_drive(1'b1, 1'b1, 1'b1, 8'h5A);
    endtask

    initial begin
        logic       log_bits [9];
        logic [8:0] pat_3c;

        for (int k = 0; k < NCYC; k++) begin
            exp_rv[k]   = 1'b0;
            exp_rd[k]   = '0;
            exp_miso[k] = 1'b0;
        end

        // Reset state
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) edge_drive(1'b1, 1'b0, 1'b0, '0);
        check("reset_rx_data", rx_data, 10'h000);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_miso", miso, 1'b0);
        check("reset_state", dut.state, IDLE);
        check("reset_rd_addr_seen", dut.rd_addr_seen, 1'b0);
        rst_n = 1'b1;
        edge_drive(1'b1, 1'b0, 1'b0, '0);

        // Write address then data, with spurious tx_valid and extra MOSI bits
        send_header(1'b0);
        send_word(10'h0A5, WW, 1'b1);
        hold(3, 1'b1);
        check("write1_rx_data", rx_data, 10'h0A5);
        end_frame();
        send_header(1'b0);
        send_word(10'h13C, WW, 1'b1);
        hold(2, 1'b1);
        check("write2_rx_data", rx_data, 10'h13C);
        end_frame();

        // Read address then read data returning 0x3C
        send_header(1'b1);
        send_word(10'h2A5, WW, 1'b0);
        check("rdadd_rx_data", rx_data, 10'h2A5);
        check("rdadd_seen_set", dut.rd_addr_seen, 1'b1);
        hold(2, 1'b0);
        end_frame();
        send_header(1'b1);
        send_word(10'h300, WW, 1'b0);
        check("rddata_seen_clr", dut.rd_addr_seen, 1'b0);
        send_tx(8'h3C, 2);
        log_bits[0] = miso;
        for (int j = 1; j < 9; j++) begin
            edge_drive(1'b0, 1'b1, 1'b1, 8'hAA);
            log_bits[j] = miso;
        end
        pat_3c = 9'b0_0111_1000;
        for (int j = 0; j < 9; j++) check("miso_3c_pattern", log_bits[j], pat_3c[8-j]);
        end_frame();

        // Abort after 6 word bits, then a full frame
        send_header(1'b0);
        send_word(10'h155, 6, 1'b0);
        end_frame();
        send_header(1'b0);
        send_word(10'h0F0, WW, 1'b0);
        end_frame();
        check("after_abort_rx_data", rx_data, 10'h0F0);

        // ss_n rising on the 10th-bit edge: no strobe, rx_data unchanged
        send_header(1'b0);
        send_word(10'h3FF, WW - 1, 1'b0);
        end_frame();
        check("coincident_rx_data", rx_data, 10'h0F0);

        // rd_addr_seen survives an aborted READ_DATA frame
        send_header(1'b1);
        send_word(10'h211, WW, 1'b0);
        end_frame();
        send_header(1'b1);
        send_word(10'h2C3, 4, 1'b0);
        end_frame();
        check("seen_kept_abort", dut.rd_addr_seen, 1'b1);

        // Reset in the middle of a 0xFF shift-out
        send_header(1'b1);
        send_word(10'h301, WW, 1'b0);
        send_tx(8'hFF, 0);
        edge_drive(1'b0, 1'b0, 1'b0, '0);
        edge_drive(1'b0, 1'b0, 1'b0, '0);
        check("miso_before_reset", miso, 1'b1);
        clear_miso_exp(cyc);
        rst_n      = 1'b0;
        model_seen = 1'b0;
        tx_armed   = 1'b0;
        edge_drive(1'b0, 1'b0, 1'b0, '0);
        check("rst_mid_miso", miso, 1'b0);
        check("rst_mid_state", dut.state, IDLE);
        check("rst_mid_seen", dut.rd_addr_seen, 1'b0);
        edge_drive(1'b1, 1'b0, 1'b0, '0);
        rst_n = 1'b1;
        edge_drive(1'b1, 1'b0, 1'b0, '0);

        // Recovery frame after reset
        send_header(1'b0);
        send_word(10'h1C3, WW, 1'b0);
        end_frame();
        check("recover_rx_data", rx_data, 10'h1C3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
